// File: rtl/grad_accumulate.sv
// Accumulates one gradient sample G into the running tensor A element by element,
// optionally applying an arithmetic right shift on the last sample of a batch.
module grad_accumulate #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              batch_first,
  input  logic              batch_last,
  input  logic [4:0]        scale_shift,
  output logic              done,
  output logic              error,
  input  logic [ADDR_W-1:0] g_region_begin,
  input  logic [ADDR_W-1:0] g_region_end,
  input  logic [ADDR_W-1:0] a_region_begin,
  input  logic [ADDR_W-1:0] a_region_end,
  output logic              g_r_en,
  output logic [ADDR_W-1:0] g_ptr,
  input  logic [DATA_W-1:0] g_data_load,
  input  logic              g_done,
  output logic              a_r_en,
  output logic              a_w_en,
  output logic [ADDR_W-1:0] a_ptr,
  output logic [DATA_W-1:0] a_data_store,
  input  logic [DATA_W-1:0] a_data_load,
  input  logic              a_done,
  output logic [2:0]        dbg_state_o
);

  // Memory ports: a request (r_en or w_en with ptr/data_store) is held stable until the
  // one-cycle done pulse is sampled, and dropped on that same clock edge.

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_G, S_HDR_A, S_RD, S_WR, S_FIN, S_ERR
  } state_t;

  localparam int CW = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;

  state_t              state_q, state_d;
  logic                bf_q, bf_d, bl_q, bl_d;
  logic [4:0]          shift_q, shift_d;
  logic [ADDR_W-1:0]   gb_q, gb_d, ge_q, ge_d, ab_q, ab_d, ae_q, ae_d;
  logic [DATA_W-1:0]   n_q, n_d, i_q, i_d;
  logic [DATA_W-1:0]   g_val_q, g_val_d, a_val_q, a_val_d;
  logic                g_got_q, g_got_d, a_got_q, a_got_d;
  logic                done_q, done_d, error_q, error_d;

  logic [ADDR_W-1:0]        elem_off;
  logic [DATA_W-1:0]        sum_w, store_w;
  logic signed [DATA_W-1:0] shifted_w;
  logic                     size_bad;

  assign elem_off  = ADDR_W'(i_q) + ADDR_W'(1);
  assign sum_w     = (bf_q ? '0 : a_val_q) + g_val_q;
  assign shifted_w = $signed(sum_w) >>> shift_q;
  assign store_w   = bl_q ? shifted_w : sum_w;

  // Extra bit keeps begin+1+N from wrapping past the region end.
  assign size_bad = (CW'(gb_q) + CW'(g_data_load) + CW'(1) > CW'(ge_q)) ||
                    (CW'(ab_q) + CW'(g_data_load) + CW'(1) > CW'(ae_q));

  always_comb begin
    state_d = state_q;
    bf_d = bf_q;  bl_d = bl_q;  shift_d = shift_q;
    gb_d = gb_q;  ge_d = ge_q;  ab_d = ab_q;  ae_d = ae_q;
    n_d = n_q;  i_d = i_q;
    g_val_d = g_val_q;  a_val_d = a_val_q;
    g_got_d = g_got_q;  a_got_d = a_got_q;
    g_r_en = 1'b0;  g_ptr = '0;
    a_r_en = 1'b0;  a_w_en = 1'b0;  a_ptr = '0;  a_data_store = '0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          bf_d = batch_first;  bl_d = batch_last;  shift_d = scale_shift;
          gb_d = g_region_begin;  ge_d = g_region_end;
          ab_d = a_region_begin;  ae_d = a_region_end;
          state_d = S_HDR_G;
        end
      end
      S_HDR_G: begin
        g_r_en = 1'b1;
        g_ptr  = gb_q;
        if (g_done) begin
          n_d     = g_data_load;
          state_d = size_bad ? S_ERR : S_HDR_A;
        end
      end
      S_HDR_A: begin
        a_ptr        = ab_q;
        a_w_en       = bf_q;
        a_r_en       = !bf_q;
        a_data_store = bf_q ? n_q : '0;
        if (a_done) begin
          i_d = '0;  g_got_d = 1'b0;  a_got_d = 1'b0;
          if (!bf_q && (a_data_load != n_q)) state_d = S_ERR;
          else if (n_q == '0)               state_d = S_FIN;
          else                              state_d = S_RD;
        end
      end
      S_RD: begin
        g_ptr  = gb_q + elem_off;
        a_ptr  = ab_q + elem_off;
        g_r_en = !g_got_q;
        a_r_en = !bf_q && !a_got_q;
        if (g_done && !g_got_q) begin
          g_val_d = g_data_load;
          g_got_d = 1'b1;
        end
        if (a_done && a_r_en) begin
          a_val_d = a_data_load;
          a_got_d = 1'b1;
        end
        if (g_got_d && (a_got_d || bf_q)) state_d = S_WR;
      end
      S_WR: begin
        a_w_en       = 1'b1;
        a_ptr        = ab_q + elem_off;
        a_data_store = store_w;
        if (a_done) begin
          g_got_d = 1'b0;  a_got_d = 1'b0;
          if (i_q == n_q - DATA_W'(1)) state_d = S_FIN;
          else begin
            i_d     = i_q + DATA_W'(1);
            state_d = S_RD;
          end
        end
      end
      S_FIN:   if (!go) state_d = S_IDLE;
      S_ERR:   if (!go) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d  = (state_d == S_FIN) || (state_d == S_ERR);
    error_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bf_q <= 1'b0;  bl_q <= 1'b0;  shift_q <= '0;
      gb_q <= '0;  ge_q <= '0;  ab_q <= '0;  ae_q <= '0;
      n_q <= '0;  i_q <= '0;
      g_val_q <= '0;  a_val_q <= '0;
      g_got_q <= 1'b0;  a_got_q <= 1'b0;
      done_q <= 1'b0;  error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bf_q <= bf_d;  bl_q <= bl_d;  shift_q <= shift_d;
      gb_q <= gb_d;  ge_q <= ge_d;  ab_q <= ab_d;  ae_q <= ae_d;
      n_q <= n_d;  i_q <= i_d;
      g_val_q <= g_val_d;  a_val_q <= a_val_d;
      g_got_q <= g_got_d;  a_got_q <= a_got_d;
      done_q <= done_d;  error_q <= error_d;
    end
  end

  assign done        = done_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_grad_accumulate.sv
// Bench for grad_accumulate: memory responders with random latency, a directed
// vector table, randomized batches against a plain-arithmetic model, and a reset-abort case.
module tb_grad_accumulate;
  localparam logic [31:0] GB  = 32'd16;
  localparam logic [31:0] AB  = 32'd64;
  localparam logic [31:0] RGB = 32'd32;
  localparam logic [31:0] RAB = 32'd128;
  localparam logic [31:0] D3 = 32'hDEAD0003, D4 = 32'hDEAD0004, D5 = 32'hDEAD0005;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, go, batch_first, batch_last;
  logic [4:0]  scale_shift;
  logic        done, error;
  logic [31:0] g_region_begin, g_region_end, a_region_begin, a_region_end;
  logic        g_r_en, g_done, a_r_en, a_w_en, a_done;
  logic [31:0] g_ptr, g_data_load, a_ptr, a_data_store, a_data_load;
  logic [2:0]  dbg_state;

  grad_accumulate dut (
    .clk(clk), .rst(rst), .go(go), .batch_first(batch_first), .batch_last(batch_last),
    .scale_shift(scale_shift), .done(done), .error(error),
    .g_region_begin(g_region_begin), .g_region_end(g_region_end),
    .a_region_begin(a_region_begin), .a_region_end(a_region_end),
    .g_r_en(g_r_en), .g_ptr(g_ptr), .g_data_load(g_data_load), .g_done(g_done),
    .a_r_en(a_r_en), .a_w_en(a_w_en), .a_ptr(a_ptr), .a_data_store(a_data_store),
    .a_data_load(a_data_load), .a_done(a_done), .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:255];
  logic [31:0] cur_ab;
  int lat_min = 1, lat_max = 3;
  int a_el_rd_n, a_el_wr_n, rw_overlap_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // G port responder: done after 1..N cycles of held request, data valid only with done.
  initial begin
    g_done = 1'b0;
    g_data_load = '0;
    forever begin
      @(negedge clk); #1;
      g_done = 1'b0;
      g_data_load = $urandom;
      if (g_r_en && !rst) begin
        logic [31:0] p;
        int lat;
        bit ok, aborted;
        p = g_ptr;  ok = 1'b1;  aborted = 1'b0;
        lat = $urandom_range(lat_max, lat_min);
        for (int k = 0; k < lat; k++) begin
          @(negedge clk); #1;
          g_data_load = $urandom;
          if (rst) begin aborted = 1'b1; break; end
          if (!g_r_en || g_ptr !== p) ok = 1'b0;
        end
        if (!aborted) begin
          g_done = 1'b1;
          g_data_load = mem[p[7:0]];
          check("g_req_held", {31'd0, ok}, 32'd1);
        end
      end
    end
  end

  // A port responder: reads and writes; a write lands only on the edge that samples done.
  initial begin
    a_done = 1'b0;
    a_data_load = '0;
    forever begin
      @(negedge clk); #1;
      a_done = 1'b0;
      a_data_load = $urandom;
      if ((a_r_en || a_w_en) && !rst) begin
        logic [31:0] p, d;
        bit wr, ok, aborted;
        int lat;
        p = a_ptr;  d = a_data_store;  wr = a_w_en;  ok = 1'b1;  aborted = 1'b0;
        lat = $urandom_range(lat_max, lat_min);
        for (int k = 0; k < lat; k++) begin
          @(negedge clk); #1;
          a_data_load = $urandom;
          if (rst) begin aborted = 1'b1; break; end
          if (a_w_en !== wr || a_r_en !== !wr || a_ptr !== p || (wr && a_data_store !== d)) ok = 1'b0;
        end
        if (!aborted) begin
          a_done = 1'b1;
          if (!wr) a_data_load = mem[p[7:0]];
          check("a_req_held", {31'd0, ok}, 32'd1);
          @(posedge clk);
          if (!rst) begin
            if (wr) mem[p[7:0]] = d;
            if (p != cur_ab) begin
              if (wr) a_el_wr_n++;
              else    a_el_rd_n++;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) if ((a_r_en && a_w_en) || (g_r_en && a_w_en && 1'b0)) rw_overlap_n++;

  task automatic run_op(input logic [31:0] gb, ge, ab, ae, input bit bf, bl,
                        input logic [4:0] sh, input bit early_drop, input string tag,
                        output bit got_err);
    bit got_done;
    cur_ab = ab;
    a_el_rd_n = 0;
    a_el_wr_n = 0;
    got_done = 1'b0;
    got_err = 1'b0;
    @(negedge clk);
    go = 1'b1;  batch_first = bf;  batch_last = bl;  scale_shift = sh;
    g_region_begin = gb;  g_region_end = ge;  a_region_begin = ab;  a_region_end = ae;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        batch_first = $urandom;  batch_last = $urandom;  scale_shift = $urandom;
        g_region_begin = $urandom;  g_region_end = $urandom;
        a_region_begin = $urandom;  a_region_end = $urandom;
      end
      if (early_drop && c == 2) go = 1'b0;
      if (done) begin
        got_done = 1'b1;
        got_err = error;
        break;
      end
    end
    check($sformatf("%s done_seen", tag), {31'd0, got_done}, 32'd1);
    if (got_done && !early_drop) begin
      @(negedge clk);
      check($sformatf("%s done_held", tag), {31'd0, done}, 32'd1);
      go = 1'b0;
    end
    @(negedge clk);
    go = 1'b0;
    check($sformatf("%s done_clear", tag), {30'd0, done, error}, 32'd0);
  endtask

  typedef struct {
    bit bf; bit bl; logic [4:0] sh;
    bit set_ahdr; logic [31:0] ahdr; logic [31:0] n;
    int g_slack; int a_slack;
    logic [31:0] g [0:5];
    bit exp_err; logic [31:0] exp_ahdr; int exp_wr; int exp_rd;
    logic [31:0] exp_a [0:5];
  } vec_t;

  localparam int NROWS = 11;
  vec_t tbl [0:NROWS-1];

  // Reference model for the randomized batches.
  logic [31:0] m_el [0:5];
  logic [31:0] m_hdr;

  task automatic model_apply(input bit bf, bl, input logic [4:0] sh, input int n,
                             input logic [31:0] g [0:5]);
    for (int i = 0; i < n; i++) begin
      logic [31:0] s;
      s = (bf ? 32'd0 : m_el[i]) + g[i];
      if (bl) s = $signed(s) >>> sh;
      m_el[i] = s;
    end
    if (bf) m_hdr = n;
  endtask

  task automatic compare_model(input string tag, input int n, input bit bf, input bit err);
    check($sformatf("%s error", tag), {31'd0, err}, 32'd0);
    check($sformatf("%s a_hdr", tag), mem[RAB[7:0]], m_hdr);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s a[%0d]", tag, i), mem[RAB[7:0] + 8'(i) + 8'd1], m_el[i]);
    check($sformatf("%s el_writes", tag), a_el_wr_n, n);
    check($sformatf("%s el_reads", tag), a_el_rd_n, bf ? 0 : n);
  endtask

  task automatic make_g(input int n, output logic [31:0] g [0:5]);
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 3) == 0) g[i] = $urandom;
      else g[i] = 32'($urandom_range(0, 200)) - 32'd100;
    end
    mem[RGB[7:0]] = n;
    for (int i = 0; i < n; i++) mem[RGB[7:0] + 8'(i) + 8'd1] = g[i];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit err;
    logic [31:0] g [0:5];
    tbl[0]  = '{1'b1, 1'b0, 5'd0,  1'b0, 32'd0, 32'd3, 0, 2, '{5, -2, 7, 0, 0, 0},
                1'b0, 32'd3, 3, 0, '{5, -2, 7, D3, D4, D5}};
    tbl[1]  = '{1'b0, 1'b1, 5'd1,  1'b0, 32'd0, 32'd3, 0, 2, '{3, 4, -9, 0, 0, 0},
                1'b0, 32'd3, 3, 3, '{4, 1, -1, D3, D4, D5}};
    tbl[2]  = '{1'b0, 1'b0, 5'd0,  1'b1, 32'd4, 32'd3, 0, 2, '{1, 1, 1, 0, 0, 0},
                1'b1, 32'd4, 0, 0, '{4, 1, -1, D3, D4, D5}};
    tbl[3]  = '{1'b1, 1'b0, 5'd0,  1'b0, 32'd0, 32'd0, 0, 2, '{9, 9, 9, 0, 0, 0},
                1'b0, 32'd0, 0, 0, '{4, 1, -1, D3, D4, D5}};
    tbl[4]  = '{1'b1, 1'b0, 5'd0,  1'b0, 32'd0, 32'd6, -1, 2, '{9, 9, 9, 9, 9, 9},
                1'b1, 32'd0, 0, 0, '{4, 1, -1, D3, D4, D5}};
    tbl[5]  = '{1'b1, 1'b0, 5'd0,  1'b0, 32'd0, 32'd6, 0, 0, '{10, 20, 30, 40, 50, 60},
                1'b0, 32'd6, 6, 0, '{10, 20, 30, 40, 50, 60}};
    tbl[6]  = '{1'b0, 1'b1, 5'd4,  1'b0, 32'd0, 32'd6, 0, 0, '{6, -36, 0, -41, 1, 4},
                1'b0, 32'd6, 6, 6, '{1, -1, 1, -1, 3, 4}};
    tbl[7]  = '{1'b1, 1'b0, 5'd0,  1'b0, 32'd0, 32'd1, 0, 2, '{32'h7FFFFFFF, 0, 0, 0, 0, 0},
                1'b0, 32'd1, 1, 0, '{32'h7FFFFFFF, -1, 1, -1, 3, 4}};
    tbl[8]  = '{1'b0, 1'b0, 5'd0,  1'b0, 32'd0, 32'd1, 0, 2, '{1, 0, 0, 0, 0, 0},
                1'b0, 32'd1, 1, 1, '{32'h80000000, -1, 1, -1, 3, 4}};
    tbl[9]  = '{1'b0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd1, 0, 2, '{0, 0, 0, 0, 0, 0},
                1'b0, 32'd1, 1, 1, '{32'hFFFFFFFF, -1, 1, -1, 3, 4}};
    tbl[10] = '{1'b1, 1'b0, 5'd0,  1'b0, 32'd0, 32'd2, 2, -1, '{7, 7, 0, 0, 0, 0},
                1'b1, 32'd1, 0, 0, '{32'hFFFFFFFF, -1, 1, -1, 3, 4}};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 6; i++) mem[AB[7:0] + 8'(i) + 8'd1] = 32'hDEAD0000 + 32'(i);
    for (int i = 0; i < 6; i++) begin
      mem[RAB[7:0] + 8'(i) + 8'd1] = 32'h5A5A0000 + 32'(i);
      m_el[i] = 32'h5A5A0000 + 32'(i);
    end
    m_hdr = '0;
    rw_overlap_n = 0;
    cur_ab = AB;

    // Clock / reset
    rst = 1'b1;  go = 1'b0;  batch_first = 1'b0;  batch_last = 1'b0;  scale_shift = '0;
    g_region_begin = '0;  g_region_end = '0;  a_region_begin = '0;  a_region_end = '0;
    repeat (3) @(negedge clk);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst error", {31'd0, error}, 32'd0);
    check("rst enables", {29'd0, g_r_en, a_r_en, a_w_en}, 32'd0);
    check("rst g_ptr", g_ptr, 32'd0);
    check("rst a_ptr", a_ptr, 32'd0);
    check("rst a_data_store", a_data_store, 32'd0);
    rst = 1'b0;

    // Directed vector table
    for (int r = 0; r < NROWS; r++) begin
      string tag;
      v = tbl[r];
      tag = $sformatf("row%0d", r);
      if (v.set_ahdr) mem[AB[7:0]] = v.ahdr;
      mem[GB[7:0]] = v.n;
      for (int i = 0; i < 6; i++) mem[GB[7:0] + 8'(i) + 8'd1] = v.g[i];
      run_op(GB, GB + 32'd1 + v.n + 32'(v.g_slack), AB, AB + 32'd1 + v.n + 32'(v.a_slack),
             v.bf, v.bl, v.sh, 1'b0, tag, err);
      check($sformatf("%s error", tag), {31'd0, err}, {31'd0, v.exp_err});
      check($sformatf("%s a_hdr", tag), mem[AB[7:0]], v.exp_ahdr);
      for (int i = 0; i < 6; i++)
        check($sformatf("%s a[%0d]", tag, i), mem[AB[7:0] + 8'(i) + 8'd1], v.exp_a[i]);
      check($sformatf("%s el_writes", tag), a_el_wr_n, v.exp_wr);
      check($sformatf("%s el_reads", tag), a_el_rd_n, v.exp_rd);
    end

    // Randomized batches; batch 1 uses fixed latency so both done pulses coincide
    for (int b = 0; b < 6; b++) begin
      int n, ns;
      n = $urandom_range(1, 6);
      ns = $urandom_range(1, 3);
      lat_min = 1;
      lat_max = (b == 1) ? 1 : 8;
      for (int s = 0; s < ns; s++) begin
        bit bf, bl, early;
        logic [4:0] sh;
        string tag;
        bf = (s == 0);
        bl = (s == ns - 1);
        sh = bl ? 5'($urandom_range(0, 31)) : 5'd0;
        early = ($urandom_range(0, 3) == 0);
        tag = $sformatf("rand b%0d s%0d", b, s);
        make_g(n, g);
        model_apply(bf, bl, sh, n, g);
        run_op(RGB, RGB + 32'd1 + 32'(n) + 32'($urandom_range(0, 3)), RAB,
               RAB + 32'd1 + 32'(n) + 32'($urandom_range(0, 3)), bf, bl, sh, early, tag, err);
        compare_model(tag, n, bf, err);
      end
    end

    // Reset while an element write is pending, then a clean rerun
    begin
      bit seen;
      int wr_before;
      lat_min = 6;
      lat_max = 6;
      make_g(3, g);
      cur_ab = RAB;
      a_el_wr_n = 0;
      @(negedge clk);
      go = 1'b1;  batch_first = 1'b1;  batch_last = 1'b0;  scale_shift = '0;
      g_region_begin = RGB;  g_region_end = RGB + 32'd4;
      a_region_begin = RAB;  a_region_end = RAB + 32'd4;
      seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (a_w_en && a_ptr != RAB) begin seen = 1'b1; break; end
      end
      check("rstmid wr_seen", {31'd0, seen}, 32'd1);
      wr_before = a_el_wr_n;
      rst = 1'b1;
      @(negedge clk);
      check("rstmid done_err", {30'd0, done, error}, 32'd0);
      check("rstmid enables", {29'd0, g_r_en, a_r_en, a_w_en}, 32'd0);
      check("rstmid a_ptr", a_ptr, 32'd0);
      check("rstmid a_data_store", a_data_store, 32'd0);
      go = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("rstmid no_write", a_el_wr_n, wr_before);
      lat_min = 1;
      lat_max = 8;
      model_apply(1'b1, 1'b0, 5'd0, 3, g);
      run_op(RGB, RGB + 32'd4, RAB, RAB + 32'd4, 1'b1, 1'b0, 5'd0, 1'b0, "rerun", err);
      compare_model("rerun", 3, 1'b1, err);
    end

    check("no_rw_overlap", rw_overlap_n, 0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
